// File: rtl/riscv_core_pkg.sv
// Shared types for the RV64M execute-stage divider.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_e;

    localparam int unsigned W_ITER = 32;

endpackage

// File: rtl/riscv_core_div_step.sv
// One radix-2 non-restoring iteration: shift in the next dividend bit, add or subtract the divisor.
module riscv_core_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;

    always_comb begin
        shifted = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
        // Wraparound in XLEN+1 bits is harmless: the true result always lies in [-dvs, dvs).
        if (rem_i[XLEN]) begin
            rem_o = shifted + {1'b0, dvs_i};
        end else begin
            rem_o = shifted - {1'b0, dvs_i};
        end
        quo_o = {quo_i[XLEN-2:0], ~rem_o[XLEN]};
    end

endmodule

// File: rtl/riscv_core_div.sv
// Iterative non-restoring divider for DIV/DIVU/REM/REMU and their W forms; one quotient bit per cycle.
module riscv_core_div
    import riscv_core_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_div_clk,
    input  logic            i_div_rst_n,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic [1:0]      i_div_control,
    input  logic            i_div_isword,
    input  logic            i_div_en,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_done,
    output logic [XLEN-1:0] o_div_result
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    div_state_e      state_q, state_d;
    div_ctrl_e       ctrl_q, ctrl_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    logic            is_signed, sgn_a, sgn_b, div_zero, sgn_ovf, special, start;
    logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, int_min, spec_sel, spec_res;
    logic [XLEN-1:0] rem_mag, quo_fin, rem_fin, fix_sel, fix_res;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sx);
        return {{(XLEN-32){sx & x[31]}}, x[31:0]};
    endfunction

    // Operand conditioning and special-case detection on the effective width
    always_comb begin
        is_signed = ~i_div_control[0];
        op_a      = i_div_srcA;
        op_b      = i_div_srcB;
        int_min   = {1'b1, {(XLEN-1){1'b0}}};
        if (i_div_isword) begin
            op_a    = ext32(i_div_srcA, is_signed);
            op_b    = ext32(i_div_srcB, is_signed);
            int_min = ext32(XLEN'(32'h8000_0000), 1'b1);
        end
        sgn_a    = is_signed & op_a[XLEN-1];
        sgn_b    = is_signed & op_b[XLEN-1];
        abs_a    = sgn_a ? -op_a : op_a;
        abs_b    = sgn_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        sgn_ovf  = is_signed & (op_a == int_min) & (op_b == '1);
        special  = div_zero | sgn_ovf;
        if (div_zero) begin
            spec_sel = i_div_control[1] ? op_a : '1;
        end else begin
            spec_sel = i_div_control[1] ? '0 : op_a;
        end
        spec_res = i_div_isword ? ext32(spec_sel, 1'b1) : spec_sel;
        start    = i_div_en & ~i_div_flush & ((state_q == IDLE) | (state_q == DONE));
    end

    riscv_core_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        rem_mag = rem_q[XLEN] ? rem_q[XLEN-1:0] + dvs_q : rem_q[XLEN-1:0];
        quo_fin = negq_q ? -quo_q : quo_q;
        rem_fin = negr_q ? -rem_mag : rem_mag;
        fix_sel = ((ctrl_q == REM) || (ctrl_q == REMU)) ? rem_fin : quo_fin;
        fix_res = word_q ? ext32(fix_sel, 1'b1) : fix_sel;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        word_d   = word_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        if (start) begin
            ctrl_d = div_ctrl_e'(i_div_control);
            word_d = i_div_isword;
            negq_d = sgn_a ^ sgn_b;
            negr_d = sgn_a;
            rem_d  = '0;
            // W dividends sit in the top half so their MSB is shifted in first
            quo_d  = i_div_isword ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
            dvs_d  = abs_b;
            cnt_d  = i_div_isword ? CntW'(W_ITER) : CntW'(XLEN);
            if (special) begin
                result_d = spec_res;
            end
        end else if (state_q == CALC) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CntW'(1);
        end else if ((state_q == FIXUP) && !i_div_flush) begin
            result_d = fix_res;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = special ? DONE : CALC;
            CALC: begin
                if (i_div_flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP:   state_d = i_div_flush ? IDLE : DONE;
            DONE:    state_d = start ? (special ? DONE : CALC) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_div_clk) begin
        if (!i_div_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_div_clk) begin
        if (!i_div_rst_n) begin
            ctrl_q   <= DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            word_q   <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            word_q   <= word_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    always_comb begin
        o_div_busy   = (state_q == CALC) || (state_q == FIXUP);
        o_div_done   = (state_q == DONE);
        o_div_result = result_q;
    end

endmodule
